// File: rtl/usb_rx_pkt_ctrl_if.sv
// ---------------------------------------------------------------------------
// usb_rx_pkt_ctrl_if
//   Bundles everything the packet controller sees and drives, apart from
//   clock and reset.
//   master : upstream and host side. Drives the receiver inputs, fifo_full
//            and status_ack. Observes the FIFO write port and the status
//            record.
//   slave  : the packet controller.
//   Receiver inputs : rcving, w_enable, r_error, rcv_data[7:0]
//   FIFO            : fifo_full (in), fifo_wr, fifo_wdata[7:0], fifo_flush (out)
//   Status record   : status_ack (in), pkt_valid, pkt_pid[3:0],
//                     pkt_len[LEN_W-1:0], pkt_err[3:0] (out)
//   Misc            : busy, missed_cnt[3:0] (out)
// ---------------------------------------------------------------------------
interface usb_rx_pkt_ctrl_if #(
  parameter int LEN_W = 7
) ();
  logic             rcving;
  logic             w_enable;
  logic             r_error;
  logic [7:0]       rcv_data;
  logic             fifo_full;
  logic             status_ack;
  logic             fifo_wr;
  logic [7:0]       fifo_wdata;
  logic             fifo_flush;
  logic             pkt_valid;
  logic [3:0]       pkt_pid;
  logic [LEN_W-1:0] pkt_len;
  logic [3:0]       pkt_err;
  logic             busy;
  logic [3:0]       missed_cnt;

  modport master (
    output rcving, w_enable, r_error, rcv_data, fifo_full, status_ack,
    input  fifo_wr, fifo_wdata, fifo_flush, pkt_valid, pkt_pid, pkt_len,
           pkt_err, busy, missed_cnt
  );

  modport slave (
    input  rcving, w_enable, r_error, rcv_data, fifo_full, status_ack,
    output fifo_wr, fifo_wdata, fifo_flush, pkt_valid, pkt_pid, pkt_len,
           pkt_err, busy, missed_cnt
  );
endinterface

// File: rtl/usb_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// usb_rx_pkt_ctrl
//   Packet-level controller for the USB receiver.
//   - The first byte of each packet is the PID. Every later byte is data and
//     is streamed into the RX FIFO.
//   - Tracks four packet errors: a bad or missing PID, a receiver error,
//     a length overflow and a FIFO overflow.
//   - At the end of each packet, loads a status record (pid/len/err) and
//     holds it until the host acknowledges it. If the packet had any error,
//     pulses fifo_flush.
//   Ports:
//     clk  : clock. All logic runs on the rising edge.
//     rst  : synchronous active-high reset.
//     bus  : usb_rx_pkt_ctrl_if.slave. Carries the receiver inputs, the FIFO
//            write port and the status record.
// ---------------------------------------------------------------------------
module usb_rx_pkt_ctrl #(
  parameter int MAX_BYTES = 64,
  parameter int LEN_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  usb_rx_pkt_ctrl_if.slave bus
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PID,
    ST_DATA,
    ST_CHECK,
    ST_REPORT
  } state_t;

  state_t           state_reg, state_next;
  logic             rcving_q_reg;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       err_reg, err_next;
  logic [3:0]       pid_reg, pid_next;
  logic             wr_reg, wr_next;
  logic [7:0]       wdata_reg, wdata_next;
  logic [3:0]       pkt_pid_reg, pkt_pid_next;
  logic [LEN_W-1:0] pkt_len_reg, pkt_len_next;
  logic [3:0]       pkt_err_reg, pkt_err_next;
  logic [3:0]       missed_reg, missed_next;
  logic             flush;
  logic             rise, fall;

  assign rise = bus.rcving & ~rcving_q_reg;
  assign fall = ~bus.rcving & rcving_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rcving_q_reg <= 1'b0;
      cnt_reg      <= '0;
      err_reg      <= '0;
      pid_reg      <= '0;
      wr_reg       <= 1'b0;
      wdata_reg    <= '0;
      pkt_pid_reg  <= '0;
      pkt_len_reg  <= '0;
      pkt_err_reg  <= '0;
      missed_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      rcving_q_reg <= bus.rcving;
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
      pid_reg      <= pid_next;
      wr_reg       <= wr_next;
      wdata_reg    <= wdata_next;
      pkt_pid_reg  <= pkt_pid_next;
      pkt_len_reg  <= pkt_len_next;
      pkt_err_reg  <= pkt_err_next;
      missed_reg   <= missed_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    err_next     = err_reg;
    pid_next     = pid_reg;
    wr_next      = 1'b0;
    wdata_next   = wdata_reg;
    pkt_pid_next = pkt_pid_reg;
    pkt_len_next = pkt_len_reg;
    pkt_err_next = pkt_err_reg;
    missed_next  = missed_reg;
    flush        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Only a fresh rising edge starts a packet. If rcving is already high
        // when we return here, the rest of that packet is ignored.
        if (rise) begin
          state_next = ST_PID;
          cnt_next   = '0;
          err_next   = '0;
          pid_next   = '0;
        end
      end

      ST_PID: begin
        if (bus.r_error) err_next[1] = 1'b1;
        if (bus.w_enable) begin
          pid_next = bus.rcv_data[3:0];
          // A valid PID carries its own ones' complement in the upper nibble.
          if (bus.rcv_data[3:0] != ~bus.rcv_data[7:4]) err_next[0] = 1'b1;
          state_next = fall ? ST_CHECK : ST_DATA;
        end else if (fall) begin
          err_next[0] = 1'b1;
          pid_next    = '0;
          state_next  = ST_CHECK;
        end
      end

      ST_DATA: begin
        if (bus.r_error) err_next[1] = 1'b1;
        // A byte arriving together with the fall is still handled before
        // the packet closes.
        if (bus.w_enable) begin
          if (cnt_reg == MAX_LEN) begin
            err_next[2] = 1'b1;
          end else if (bus.fifo_full) begin
            err_next[3] = 1'b1;
          end else begin
            wr_next    = 1'b1;
            wdata_next = bus.rcv_data;
            cnt_next   = cnt_reg + 1'b1;
          end
        end
        if (fall) state_next = ST_CHECK;
      end

      ST_CHECK: begin
        pkt_pid_next = pid_reg;
        pkt_len_next = cnt_reg;
        pkt_err_next = err_reg;
        flush        = |err_reg;
        state_next   = ST_REPORT;
      end

      ST_REPORT: begin
        // A packet that starts while the status record is still unread is
        // lost. Count it, and never write its bytes.
        if (rise && missed_reg != 4'd15) missed_next = missed_reg + 4'd1;
        if (bus.status_ack) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.fifo_wr    = wr_reg;
  assign bus.fifo_wdata = wdata_reg;
  assign bus.fifo_flush = flush;
  assign bus.pkt_valid  = (state_reg == ST_REPORT);
  assign bus.pkt_pid    = pkt_pid_reg;
  assign bus.pkt_len    = pkt_len_reg;
  assign bus.pkt_err    = pkt_err_reg;
  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.missed_cnt = missed_reg;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
module tb_usb_rx_pkt_ctrl;
  localparam int MAXB  = 4;
  localparam int LEN_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usb_rx_pkt_ctrl_if #(.LEN_W(LEN_W)) bus ();

  usb_rx_pkt_ctrl #(.MAX_BYTES(MAXB), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] pid;
    int         len;
    logic [3:0] err;
    bit         flush;
    int         vcyc;
  } stat_t;

  logic [7:0] exp_wr_q [$];
  stat_t      exp_stat_q [$];
  stat_t      cur;
  bit         flush_seen = 1'b0;
  logic       valid_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: checks FIFO writes and status records against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.fifo_wr) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          logic [7:0] e;
          e = exp_wr_q.pop_front();
          chk("wr_data", bus.fifo_wdata, e);
          $display("fifo write %02h (expected %02h)", bus.fifo_wdata, e);
        end
      end
      if (bus.fifo_flush) flush_seen = 1'b1;
      if (bus.pkt_valid && !valid_q) begin
        if (exp_stat_q.size() == 0) chk("stat_unexpected", 1, 0);
        else begin
          cur = exp_stat_q.pop_front();
          chk("stat_pid", bus.pkt_pid, cur.pid);
          chk("stat_len", bus.pkt_len, cur.len);
          chk("stat_err", bus.pkt_err, cur.err);
          chk("stat_flush", flush_seen, cur.flush);
          chk("stat_latency", cyc, cur.vcyc);
          $display("status pid=%h len=%0d err=%b flush=%0d", bus.pkt_pid, bus.pkt_len,
                   bus.pkt_err, flush_seen);
        end
        flush_seen = 1'b0;
      end else if (bus.pkt_valid) begin
        chk("stat_held", {bus.pkt_pid, 5'(bus.pkt_len), bus.pkt_err},
            {cur.pid, 5'(cur.len), cur.err});
      end
    end
    valid_q = bus.pkt_valid;
  end

  // Drives one packet and predicts its FIFO writes and status record.
  // b[0] is the PID. full_idx is the index of the byte that sees fifo_full.
  // rerr_idx is the index of the byte after which r_error pulses.
  // An ignored packet expects nothing.
  task automatic send_pkt(input logic [7:0] b [8], input int nb, input int full_idx,
                          input int rerr_idx, input bit ignored);
    stat_t e;
    e.pid = '0; e.len = 0; e.err = '0; e.flush = 1'b0; e.vcyc = 0;
    if (!ignored) begin
      if (nb == 0) e.err[0] = 1'b1;
      else begin
        e.pid = b[0][3:0];
        if (b[0][3:0] != ~b[0][7:4]) e.err[0] = 1'b1;
        for (int i = 1; i < nb; i++) begin
          if (e.len == MAXB) e.err[2] = 1'b1;
          else if (i == full_idx) e.err[3] = 1'b1;
          else begin
            exp_wr_q.push_back(b[i]);
            e.len++;
          end
        end
      end
      if (rerr_idx >= 0) e.err[1] = 1'b1;
      e.flush = (e.err != 4'd0);
    end
    bus.rcving = 1'b1;
    step();
    for (int i = 0; i < nb; i++) begin
      bus.w_enable = 1'b1; bus.rcv_data = b[i]; bus.fifo_full = (i == full_idx);
      step();
      bus.w_enable = 1'b0; bus.fifo_full = 1'b0;
      if (i == rerr_idx) bus.r_error = 1'b1;
      step();
      bus.r_error = 1'b0;
    end
    bus.rcving = 1'b0;
    step();
    if (!ignored) begin
      e.vcyc = cyc + 1;
      exp_stat_q.push_back(e);
      step(); step(); step();
      chk("stat_seen", exp_stat_q.size(), 0);
      chk("valid_held", bus.pkt_valid, 1);
    end else begin
      step();
    end
  endtask

  task automatic do_ack();
    bus.status_ack = 1'b1;
    step();
    bus.status_ack = 1'b0;
    chk("valid_drop", bus.pkt_valid, 0);
    chk("busy_idle", bus.busy, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr"}, bus.fifo_wr, 0);
    chk({tag, "_wdata"}, bus.fifo_wdata, 0);
    chk({tag, "_flush"}, bus.fifo_flush, 0);
    chk({tag, "_valid"}, bus.pkt_valid, 0);
    chk({tag, "_pkt"}, {bus.pkt_pid, 5'(bus.pkt_len), bus.pkt_err}, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_missed"}, bus.missed_cnt, 0);
  endtask

  initial begin
    bus.rcving = 1'b0; bus.w_enable = 1'b0; bus.r_error = 1'b0;
    bus.rcv_data = '0; bus.fifo_full = 1'b0; bus.status_ack = 1'b0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Good packet: a stray ack is ignored, and the status is held until ack.
    send_pkt('{8'hC3, 8'h11, 8'h22, 8'h33, 0, 0, 0, 0}, 4, -1, -1, 1'b0);
    step(); step();
    chk("hold_valid", bus.pkt_valid, 1);
    do_ack();
    // Bad PID.
    send_pkt('{8'hC4, 8'h5A, 8'hA5, 0, 0, 0, 0, 0}, 3, -1, -1, 1'b0);
    do_ack();
    // Length overflow: 6 data bytes with MAX_BYTES=4.
    send_pkt('{8'h69, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 0}, 7, -1, -1, 1'b0);
    do_ack();
    // FIFO full during data byte 2 of 3.
    send_pkt('{8'hE1, 8'h10, 8'h20, 8'h30, 0, 0, 0, 0}, 4, 2, -1, 1'b0);
    do_ack();
    // r_error pulse mid-DATA.
    send_pkt('{8'hD2, 8'h7E, 8'h7F, 0, 0, 0, 0, 0}, 3, -1, 1, 1'b0);
    do_ack();
    // Fall with no bytes.
    send_pkt('{0, 0, 0, 0, 0, 0, 0, 0}, 0, -1, -1, 1'b0);
    do_ack();

    // Missed packet while the status is held.
    send_pkt('{8'hA5, 8'h44, 0, 0, 0, 0, 0, 0}, 2, -1, -1, 1'b0);
    send_pkt('{8'h87, 8'h91, 8'h92, 8'h93, 0, 0, 0, 0}, 4, -1, -1, 1'b1);
    chk("missed_one", bus.missed_cnt, 1);
    chk("missed_valid", bus.pkt_valid, 1);
    // Ack in the middle of another missed packet. Its remaining bytes must
    // not start a packet.
    bus.rcving = 1'b1; step();
    bus.w_enable = 1'b1; bus.rcv_data = 8'hC3; step(); bus.w_enable = 1'b0;
    do_ack();
    for (int i = 0; i < 2; i++) begin
      bus.w_enable = 1'b1; bus.rcv_data = 8'(8'h50 + i); step();
      bus.w_enable = 1'b0; step();
    end
    chk("mid_busy", bus.busy, 0);
    bus.rcving = 1'b0; step(); step(); step();
    chk("missed_two", bus.missed_cnt, 2);
    chk("mid_no_stat", bus.pkt_valid, 0);
    send_pkt('{8'hB4, 8'hDE, 8'hAD, 0, 0, 0, 0, 0}, 3, -1, -1, 1'b0);
    do_ack();

    // Reset in DATA after two writes.
    bus.rcving = 1'b1; step();
    bus.w_enable = 1'b1; bus.rcv_data = 8'hC3; step(); bus.w_enable = 1'b0; step();
    exp_wr_q.push_back(8'hAA); exp_wr_q.push_back(8'hBB);
    bus.w_enable = 1'b1; bus.rcv_data = 8'hAA; step(); bus.w_enable = 1'b0; step();
    bus.w_enable = 1'b1; bus.rcv_data = 8'hBB; step(); bus.w_enable = 1'b0; step();
    rst = 1'b1;
    step();
    chk_all_zero("midrst");
    bus.rcving = 1'b0;
    step();
    rst = 1'b0;
    step();
    send_pkt('{8'hF0, 8'hCA, 8'hFE, 8'h12, 0, 0, 0, 0}, 4, -1, -1, 1'b0);
    do_ack();

    step(); step();
    chk("wr_q_drained", exp_wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/usb_rx_pkt_ctrl.md
Name: usb_rx_pkt_ctrl

Overview:
- Packet-level controller for the USB receiver. Sits downstream of the receiver control unit and consumes its rcving / w_enable / r_error outputs and the shifted rcv_data byte.
- Splits each packet into a PID byte and data bytes, and checks PID integrity, length, FIFO overflow and receiver errors.
- Streams data bytes into the RX FIFO and presents a per-packet status record to the host side, held until acknowledged.

Parameters:
MAX_BYTES, 64, maximum data bytes (excluding PID) accepted per packet
LEN_W, 7, width of pkt_len; must satisfy 2**LEN_W > MAX_BYTES

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
rcving  input  1  high while the receiver is inside a packet
w_enable  input  1  one-cycle pulse: rcv_data holds a complete byte
r_error  input  1  receiver error indication
rcv_data  input  8  received byte, valid when w_enable=1
fifo_full  input  1  RX FIFO cannot accept a write this cycle
status_ack  input  1  host consumes the current status record
fifo_wr  output  1  RX FIFO write strobe
fifo_wdata  output  8  RX FIFO write data
fifo_flush  output  1  one-cycle pulse: discard the errored packet's FIFO contents
pkt_valid  output  1  status record valid
pkt_pid  output  4  PID[3:0] of the reported packet
pkt_len  output  LEN_W  data bytes written to the FIFO for this packet
pkt_err  output  4  [0] PID check fail/missing, [1] r_error seen, [2] length overflow, [3] FIFO overflow
busy  output  1  state is not IDLE
missed_cnt  output  4  saturating count of packets started while in REPORT

Behaviour:
- Reset: state=IDLE; every output 0; internal rcving_q=0, byte counter 0, error bits 0. Reset mid-packet aborts without a fifo_flush pulse.
- rcving_q registers rcving every cycle. rise = rcving & ~rcving_q; fall = ~rcving & rcving_q.
- IDLE: on rise -> PID, clearing counter, error bits and pkt_pid latch. A rise is the only entry; rcving already high when IDLE is entered does not start a packet.
- PID:
  - w_enable: pid_ok = (rcv_data[3:0] == ~rcv_data[7:4]). Latch rcv_data[3:0]; set err[0] if not pid_ok; -> DATA.
  - fall without any byte: err[0]=1, pid=0 -> CHECK.
- DATA, on w_enable:
  - count==MAX_BYTES: set err[2], drop byte.
  - else if fifo_full: set err[3], drop byte, count unchanged.
  - else: fifo_wr=1 and fifo_wdata=rcv_data on the next cycle (registered, 1-cycle latency); count+1.
- r_error high in any cycle while in PID or DATA sets err[1]. It is ignored in all other states.
- Fall in PID/DATA -> CHECK. If w_enable coincides with fall, the byte is processed first.
- CHECK (1 cycle):
  - Load pkt_pid, pkt_len=count and pkt_err from internal latches.
  - fifo_flush=1 this cycle if any err bit is set; otherwise 0.
  - -> REPORT.
- REPORT:
  - pkt_valid=1; pkt_* held stable.
  - status_ack -> IDLE; pkt_valid drops the cycle after ack.
  - A rise while in REPORT increments missed_cnt (saturates at 15). That packet's bytes are ignored and produce no FIFO writes.
  - status_ack concurrent with a rise: the rise still counts as missed; IDLE does not start a packet mid-stream.
- Latency: rcving first sampled 0 in cycle T -> CHECK at T+1 (flush if errored) -> pkt_valid=1 at T+2.
- status_ack outside REPORT is ignored. missed_cnt clears only on rst.
- pkt_len never exceeds MAX_BYTES; the counter does not wrap.

Test Plan:
- Good packet: rise, bytes 0xC3,0x11,0x22,0x33, fall -> fifo_wr x3 with 0x11/0x22/0x33, no flush, pkt_valid at T+2, pid=0x3, len=3, err=0; held until status_ack.
- Bad PID: byte 0xC4 then 2 data bytes -> 2 FIFO writes, flush pulse in CHECK, err=4'b0001, pid=0x4, len=2.
- Overflow (MAX_BYTES=4): PID 0x69 + 6 data bytes -> 4 writes, err[2]=1, len=4, flush=1. Separate run: fifo_full held during byte 2 of 3 -> 2 writes, err=4'b1000, len=2.
- r_error pulse mid-DATA, and fall with no bytes -> err[1]=1 in the first case; err=4'b0001, len=0 in the second; both flush.
- Missed packet: second packet (rise + 3 bytes) while pkt_valid held -> no fifo_wr, missed_cnt=1, first status unchanged; ack mid-packet -> IDLE, no new packet started until next rise.
- Reset mid-DATA after 2 writes -> all outputs 0 next cycle, no flush, busy=0; next packet processes normally.
